natv_gpio_ctrl: RTL
===================

Name: natv_gpio_ctrl

Overview:
- Parametrised GPIO controller on the native (natv) valid/ready bus.
- Successor to the fixed 8-pin GPIO registers in the native peripheral wrapper.
- Adds up to 32 pins, a configurable input synchroniser, atomic set/clear/toggle, and per-pin level/edge interrupts with W1C pending bits.
- Sits beside UART/timers on the natv bus; pad controls go to the top-level pad ring.

Parameters:
- GPIO_NUM, 16, pin count, legal 1..32.
- SYNC_STAGES, 2, input synchroniser depth, legal 2..4.
- DEBOUNCE_CYC, 4, stable cycles required by the debounce filter (macro only), legal 2..255.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- natv_valid_i  in  1  request valid
- natv_addr_i  in  32  byte address; only [7:0] decoded
- natv_wdata_i  in  32  write data
- natv_wstrb_i  in  4  byte strobes; 0 = read
- natv_rdata_o  out  32  registered read data
- natv_ready_o  out  1  one-cycle completion pulse
- gpio_out_o  out  GPIO_NUM  output value
- gpio_in_i  in  GPIO_NUM  raw pad input, asynchronous
- gpio_oeb_o  out  GPIO_NUM  output enable, active low
- gpio_pub_o  out  GPIO_NUM  pull-up enable, active low
- gpio_pdb_o  out  GPIO_NUM  pull-down enable, active low
- irq_o  out  1  combined interrupt, level

Behaviour:
- Reset: synchronous, when rst_n_i=0 at a clk_i edge. Reset values:
  - OUT = 0, OEB = all 1, PUB = all 1, PDB = all 1
  - IE = 0, ITYPE = 0, IPOL = 0, IP = 0
  - rdata = 0, ready = 0, synchroniser and edge history = 0
- Reset mid-transaction: ready stays 0 in the cycle after reset; the pending write is dropped.
- Handshake: an access executes on the edge where natv_valid_i && !ready_q. ready_q=1 on the next cycle for exactly one cycle, then returns to 0 even if valid is held, so back-to-back accesses take 2 cycles each.
- rdata is updated only on an executing edge.
- Write masking: write when wstrb != 0; byte lane k is written only if wstrb[k]. Bits at or above GPIO_NUM are never stored and read as 0.
- Register map (offset):
  - 0x00 OUT: rw.
  - 0x04 IN: ro, filtered input.
  - 0x08 OEB: rw.
  - 0x0C PUB: rw.
  - 0x10 PDB: rw.
  - 0x14 SET: wo, OUT |= wdata.
  - 0x18 CLR: wo, OUT &= ~wdata.
  - 0x1C TGL: wo, OUT ^= wdata.
  - 0x20 IE: rw.
  - 0x24 ITYPE: rw, 0 = level, 1 = edge.
  - 0x28 IPOL: rw, 0 = low/falling, 1 = high/rising.
  - 0x2C IP: read, write-1-to-clear.
  - 0x30 DEBEN: see Optional Feature.
- SET/CLR/TGL read as 0. Unmapped offsets: read 0, writes ignored, ready still pulses.
- Input path:
  - Synchroniser is SYNC_STAGES flops; sync value reflects a pad change after SYNC_STAGES edges.
  - Edge history register prev <= filt every cycle.
- Pending logic, per pin i:
  - Edge mode (ITYPE[i]=1): event = IPOL ? (filt & ~prev) : (~filt & prev). Event sets IP[i]. W1C clears it. Event and W1C on the same edge: set wins.
  - Level mode (ITYPE[i]=0): IP[i] <= (filt == IPOL) each cycle. W1C has no lasting effect while the level persists.
  - IP is set regardless of IE.
- irq_o = |(IP & IE), combinational from registers; no glitch from bus inputs. Edge irq appears SYNC_STAGES+1 edges after a pad change.
- Changing ITYPE or IPOL does not clear IP.

Optional Feature:
- Macro: NATV_GPIO_DEBOUNCE_EN.
- Defined:
  - Per-pin DEBEN register at 0x30, rw, reset 0.
  - Pin with DEBEN=1: filt updates to sync only after sync differs from filt for DEBOUNCE_CYC consecutive cycles. Per-pin 8-bit counter, reset to 0 on any mismatch break.
  - Pin with DEBEN=0: filt = sync.
- Undefined: no counters; filt = sync; 0x30 reads 0, writes ignored.

Test Plan:
- Reset, then read 0x08 (GPIO_NUM=16) -> rdata=0x0000FFFF, ready high exactly 1 cycle after valid; OUT=0, irq_o=0.
- Write OUT=0x00F0 with wstrb=0001, then SET 0x0F00, CLR 0x0030, TGL 0x0101 -> OUT=0x0EC1; SET read returns 0.
- IE=0x1, ITYPE=0x1, IPOL=0x1, drive gpio_in_i[0] 0->1 -> IP[0]=1 and irq_o=1 at edge 3 (SYNC_STAGES=2). Write IP=0x1 -> irq_o=0. Hold pin high -> stays 0.
- Level-low mode on pin 3 (IE=0x8, ITYPE=0, IPOL=0), pin held 0 -> IP=0x8. W1C while held -> IP reads 0x8 again. Pin to 1 -> IP=0 after SYNC_STAGES+1 edges.
- Edge event on same edge as W1C of that bit -> IP stays 1. Access to 0x40 -> rdata=0, ready pulses, no state change. Write 0xFFFFFFFF to OUT -> reads 0x0000FFFF.
- With NATV_GPIO_DEBOUNCE_EN, DEBEN=0x1, DEBOUNCE_CYC=4: 3-cycle pulse on pin 0 -> IN unchanged. 6-cycle pulse -> IN[0]=1 after SYNC_STAGES+4 edges.

Source files
------------

// File: rtl/natv_gpio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : natv_gpio_ctrl_if
// Description : Native (natv) valid/ready bus bundle used by the GPIO
//               controller. The master drives the request; the slave returns
//               registered read data and a one-cycle completion pulse.
// Signals     : valid - request valid
//               addr  - byte address (only [7:0] decoded by the GPIO block)
//               wdata - write data
//               wstrb - byte strobes, 0 means read
//               rdata - registered read data
//               ready - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface natv_gpio_ctrl_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, addr, wdata, wstrb, input  rdata, ready);
  modport slave  (input  valid, addr, wdata, wstrb, output rdata, ready);
endinterface
`default_nettype wire

// File: rtl/natv_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : natv_gpio_ctrl
// Description : Parametrised GPIO controller on the native valid/ready bus.
//               Up to 32 pins, configurable input synchroniser, atomic
//               set/clear/toggle of OUT, per-pin level/edge interrupts with
//               write-1-to-clear pending bits.
//               Optional debounce filter enabled by NATV_GPIO_DEBOUNCE_EN
//               (adds DEBEN register at 0x30 and per-pin 8-bit counters).
// Ports       : clk_i, rst_n_i     - clock, synchronous active-low reset
//               bus (slave)        - natv request / response bundle
//               gpio_out_o         - output value
//               gpio_in_i          - raw asynchronous pad input
//               gpio_oeb_o         - output enable, active low
//               gpio_pub_o         - pull-up enable, active low
//               gpio_pdb_o         - pull-down enable, active low
//               irq_o              - combined level interrupt |(IP & IE)
// Revision    : 1.0 - initial release
// ============================================================================
module natv_gpio_ctrl #(
  parameter int GPIO_NUM     = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  natv_gpio_ctrl_if.slave     bus,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic [GPIO_NUM-1:0] gpio_oeb_o,
  output logic [GPIO_NUM-1:0] gpio_pub_o,
  output logic [GPIO_NUM-1:0] gpio_pdb_o,
  output logic                irq_o
);

  localparam logic [7:0] ADDR_OUT   = 8'h00;
  localparam logic [7:0] ADDR_IN    = 8'h04;
  localparam logic [7:0] ADDR_OEB   = 8'h08;
  localparam logic [7:0] ADDR_PUB   = 8'h0C;
  localparam logic [7:0] ADDR_PDB   = 8'h10;
  localparam logic [7:0] ADDR_SET   = 8'h14;
  localparam logic [7:0] ADDR_CLR   = 8'h18;
  localparam logic [7:0] ADDR_TGL   = 8'h1C;
  localparam logic [7:0] ADDR_IE    = 8'h20;
  localparam logic [7:0] ADDR_ITYPE = 8'h24;
  localparam logic [7:0] ADDR_IPOL  = 8'h28;
  localparam logic [7:0] ADDR_IP    = 8'h2C;
  localparam logic [7:0] ADDR_DEBEN = 8'h30;

  logic [GPIO_NUM-1:0] out_q, oeb_q, pub_q, pdb_q;
  logic [GPIO_NUM-1:0] ie_q, itype_q, ipol_q, ip_q;
  logic [GPIO_NUM-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_NUM-1:0] sync, filt, prev_q;
  logic [GPIO_NUM-1:0] deben;
  logic                ready_q;
  logic [31:0]         rdata_q, rd_val;
  logic                exec, wr_en;
  logic [7:0]          off;
  logic [31:0]         lane_mask;
  logic [GPIO_NUM-1:0] wmask, wbits, w1c, edge_evt;

  // Upper address bits and pin-less data bits are intentionally ignored.
  wire unused_bus_bits = ^{bus.addr[31:8], bus.wdata, lane_mask, 8'(DEBOUNCE_CYC)};

  // An access executes only while no completion is outstanding, so a held
  // valid produces one access every two cycles.
  assign off       = bus.addr[7:0];
  assign exec      = bus.valid && !ready_q;
  assign wr_en     = exec && (bus.wstrb != 4'b0000);
  assign lane_mask = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}},
                      {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign wmask     = lane_mask[GPIO_NUM-1:0];
  assign wbits     = bus.wdata[GPIO_NUM-1:0] & wmask;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef NATV_GPIO_DEBOUNCE_EN
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYC - 1);

  logic [GPIO_NUM-1:0] deben_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      deben_q <= '0;
    end else if (wr_en && off == ADDR_DEBEN) begin
      deben_q <= (deben_q & ~wmask) | wbits;
    end
  end

  assign deben = deben_q;

  // The filtered level follows sync only after it has disagreed for
  // DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
  for (genvar i = 0; i < GPIO_NUM; i++) begin : g_deb
    logic [7:0] cnt_q;
    logic       filt_bit_q;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        cnt_q      <= 8'd0;
        filt_bit_q <= 1'b0;
      end else if (sync[i] == filt_bit_q) begin
        cnt_q <= 8'd0;
      end else if (cnt_q == DEB_LAST) begin
        cnt_q      <= 8'd0;
        filt_bit_q <= sync[i];
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end

    assign filt[i] = deben_q[i] ? filt_bit_q : sync[i];
  end
`else
  assign deben = '0;
  assign filt  = sync;
`endif

  // --------------------------------------------------------------------------
  // Register file and bus response
  // --------------------------------------------------------------------------
  always_comb begin
    rd_val = 32'd0;
    case (off)
      ADDR_OUT:   rd_val = 32'(out_q);
      ADDR_IN:    rd_val = 32'(filt);
      ADDR_OEB:   rd_val = 32'(oeb_q);
      ADDR_PUB:   rd_val = 32'(pub_q);
      ADDR_PDB:   rd_val = 32'(pdb_q);
      ADDR_IE:    rd_val = 32'(ie_q);
      ADDR_ITYPE: rd_val = 32'(itype_q);
      ADDR_IPOL:  rd_val = 32'(ipol_q);
      ADDR_IP:    rd_val = 32'(ip_q);
      ADDR_DEBEN: rd_val = 32'(deben);
      default:    rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_q   <= '0;
      oeb_q   <= '1;
      pub_q   <= '1;
      pdb_q   <= '1;
      ie_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= exec;
      if (exec) rdata_q <= rd_val;
      if (wr_en) begin
        case (off)
          ADDR_OUT:   out_q   <= (out_q & ~wmask) | wbits;
          ADDR_OEB:   oeb_q   <= (oeb_q & ~wmask) | wbits;
          ADDR_PUB:   pub_q   <= (pub_q & ~wmask) | wbits;
          ADDR_PDB:   pdb_q   <= (pdb_q & ~wmask) | wbits;
          ADDR_SET:   out_q   <= out_q | wbits;
          ADDR_CLR:   out_q   <= out_q & ~wbits;
          ADDR_TGL:   out_q   <= out_q ^ wbits;
          ADDR_IE:    ie_q    <= (ie_q & ~wmask) | wbits;
          ADDR_ITYPE: itype_q <= (itype_q & ~wmask) | wbits;
          ADDR_IPOL:  ipol_q  <= (ipol_q & ~wmask) | wbits;
          default:    ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt pending
  // --------------------------------------------------------------------------
  // Edge event: level changed and the new level matches the polarity.
  assign w1c      = (wr_en && off == ADDR_IP) ? wbits : '0;
  assign edge_evt = itype_q & (filt ^ prev_q) & ~(filt ^ ipol_q);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prev_q <= '0;
      ip_q   <= '0;
    end else begin
      prev_q <= filt;
      // Edge pins: a new event beats a simultaneous clear.
      // Level pins: pending simply mirrors the active level.
      ip_q   <= edge_evt
              | (itype_q & ip_q & ~w1c)
              | (~itype_q & ~(filt ^ ipol_q));
    end
  end

  assign irq_o       = |(ip_q & ie_q);
  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign gpio_out_o  = out_q;
  assign gpio_oeb_o  = oeb_q;
  assign gpio_pub_o  = pub_q;
  assign gpio_pdb_o  = pdb_q;

endmodule
`default_nettype wire
